// File: rtl/ccc_csr_writer.sv
// Turns decoded target-side CCC frames (code plus payload bytes) into one-cycle
// CSR update strobes for dynamic address, MWL/MRL and IBI-enable state.
module ccc_csr_writer #(
  parameter int MAX_BYTES = 3,
  parameter int CNT_W     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ccc_valid_i,
  output logic        ccc_ready_o,
  input  logic [7:0]  ccc_code_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  input  logic [7:0]  byte_i,
  input  logic        ccc_done_i,
  input  logic [6:0]  static_addr_i,
  input  logic        static_addr_valid_i,
  input  logic        dyn_addr_valid_i,
  output logic        dyn_addr_we_o,
  output logic [6:0]  dyn_addr_o,
  output logic        dyn_addr_valid_o,
  output logic        set_mwl_o,
  output logic [15:0] mwl_o,
  output logic        set_mrl_o,
  output logic [15:0] mrl_o,
  output logic        ibi_en_we_o,
  output logic        ibi_en_o,
  output logic        err_o,
  output logic        unsupported_o
);

  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_e;

  state_e            state_q, state_d;
  logic [7:0]        code_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        buf_q [MAX_BYTES];
  logic [6:0]        dyn_addr_q;
  logic              dyn_valid_q;
  logic [15:0]       mwl_q, mrl_q;
  logic              ibi_en_q;

  logic              dyn_we_d, mwl_we_d, mrl_we_d, ibi_we_d, err_d, unsup_d;
  logic [6:0]        addr_d;
  logic              addr_valid_d;
  logic              ibi_d;
  logic              has1, has2, commit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ccc_valid_i) state_d = COLLECT;
      COLLECT: if (ccc_done_i) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ccc_ready_o  = (state_q == IDLE) && !rst_i;
  assign byte_ready_o = (state_q == COLLECT);

  assign has1   = (cnt_q != '0);
  assign has2   = (cnt_q >= CNT_W'(2));
  assign commit = (state_q == COMMIT) && !rst_i;

  // Outcome decode, evaluated against the frame captured during COLLECT
  always_comb begin
    dyn_we_d     = 1'b0;
    mwl_we_d     = 1'b0;
    mrl_we_d     = 1'b0;
    ibi_we_d     = 1'b0;
    err_d        = 1'b0;
    unsup_d      = 1'b0;
    addr_d       = '0;
    addr_valid_d = 1'b0;
    ibi_d        = 1'b0;
    case (code_q)
      8'h06: dyn_we_d = 1'b1;
      8'h29: begin
        if (static_addr_valid_i && !dyn_addr_valid_i) begin
          dyn_we_d     = 1'b1;
          addr_d       = static_addr_i;
          addr_valid_d = 1'b1;
        end else err_d = 1'b1;
      end
      8'h87, 8'h88: begin
        if (has1 && (dyn_addr_valid_i == code_q[3])) begin
          dyn_we_d     = 1'b1;
          addr_d       = buf_q[0][7:1];
          addr_valid_d = 1'b1;
        end else err_d = 1'b1;
      end
      8'h00, 8'h80, 8'h01, 8'h81: begin
        if (!has1) err_d = 1'b1;
        else if (buf_q[0][0]) begin
          ibi_we_d = 1'b1;
          ibi_d    = !code_q[0];
        end
      end
      8'h09, 8'h89: begin
        if (has2) mwl_we_d = 1'b1;
        else err_d = 1'b1;
      end
      8'h0A, 8'h8A: begin
        if (has2) mrl_we_d = 1'b1;
        else err_d = 1'b1;
      end
      default: unsup_d = 1'b1;
    endcase
  end

  assign dyn_addr_we_o = commit && dyn_we_d;
  assign set_mwl_o     = commit && mwl_we_d;
  assign set_mrl_o     = commit && mrl_we_d;
  assign ibi_en_we_o   = commit && ibi_we_d;
  assign err_o         = commit && err_d;
  assign unsupported_o = commit && unsup_d;

  // New values appear in the strobe cycle itself; registers hold them afterwards
  assign dyn_addr_o       = dyn_addr_we_o ? addr_d : dyn_addr_q;
  assign dyn_addr_valid_o = dyn_addr_we_o ? addr_valid_d : dyn_valid_q;
  assign mwl_o            = set_mwl_o ? {buf_q[0], buf_q[1]} : mwl_q;
  assign mrl_o            = set_mrl_o ? {buf_q[0], buf_q[1]} : mrl_q;
  assign ibi_en_o         = ibi_en_we_o ? ibi_d : ibi_en_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      code_q      <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < MAX_BYTES; i++) buf_q[i] <= '0;
      dyn_addr_q  <= '0;
      dyn_valid_q <= 1'b0;
      mwl_q       <= '0;
      mrl_q       <= '0;
      ibi_en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ccc_valid_i) begin
        code_q <= ccc_code_i;
        cnt_q  <= '0;
      end
      // Bytes beyond the buffer are counted but dropped; the counter sticks at all-ones
      if (state_q == COLLECT && byte_valid_i) begin
        if (cnt_q < MAX_CNT) buf_q[cnt_q[IDX_W-1:0]] <= byte_i;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
      if (dyn_addr_we_o) begin
        dyn_addr_q  <= addr_d;
        dyn_valid_q <= addr_valid_d;
      end
      if (set_mwl_o) mwl_q <= mwl_o;
      if (set_mrl_o) mrl_q <= mrl_o;
      if (ibi_en_we_o) ibi_en_q <= ibi_d;
    end
  end

endmodule
